// File: rtl/seq_bcd_multiplier.sv
`default_nettype none
// ============================================================================
// Module   : seq_bcd_multiplier
// Purpose  : Sequential unsigned shift-add multiplier followed by a
//            double-dabble binary-to-BCD converter. Start/busy/done
//            handshake; binary product and packed BCD digits held stable
//            between results.
// Revision : 1.0 - initial release
// ============================================================================
module seq_bcd_multiplier #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      x,
  input  logic [WIDTH-1:0]      y,
  output logic                  busy,
  output logic                  done,
  output logic [2*WIDTH-1:0]    product,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int PW = 2 * WIDTH;
  localparam int BW = 4 * DIGITS;
  localparam int CW = (PW > 2) ? $clog2(PW) : 1;

  // True when DIGITS decimal digits can represent the largest product.
  function automatic bit digits_fit();
    longint unsigned p10;
    longint unsigned maxp;
    p10  = 64'd1;
    maxp = (64'd1 << WIDTH) - 64'd1;
    maxp = maxp * maxp;
    for (int i = 0; i < DIGITS; i++) begin
      p10 = p10 * 64'd10;
    end
    return p10 > maxp;
  endfunction

  localparam bit DIGITS_OK = digits_fit();

  generate
    if (!DIGITS_OK) begin : g_bad_digits
      $error("seq_bcd_multiplier: DIGITS too small for (2^WIDTH-1)^2");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_CONV = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   mcand_q;    // multiplicand, shifts left during MUL
  logic [WIDTH-1:0] mplier_q;  // multiplier, shifts right during MUL
  logic [PW-1:0]   acc_q;      // product accumulator
  logic [PW-1:0]   bin_q;      // binary half of the double-dabble register
  logic [BW-1:0]   dd_q;       // BCD half of the double-dabble register
  logic [CW-1:0]   cnt_q;      // step counter shared by MUL and CONV
  logic            busy_q;
  logic            done_q;
  logic [PW-1:0]   product_q;
  logic [BW-1:0]   bcd_q;

  logic [PW-1:0]   acc_d;
  logic [BW-1:0]   dd_adj;
  logic [BW-1:0]   dd_d;
  logic [PW-1:0]   bin_d;

  // Shift-add step: add the aligned multiplicand when the multiplier LSB is set.
  always_comb begin
    acc_d = acc_q + (mplier_q[0] ? mcand_q : {PW{1'b0}});
  end

  // Double-dabble correction: nibbles of 5 or more get +3 before the shift.
  for (genvar i = 0; i < DIGITS; i++) begin : g_dd_adj
    assign dd_adj[4*i +: 4] = (dd_q[4*i +: 4] >= 4'd5) ? (dd_q[4*i +: 4] + 4'd3)
                                                       : dd_q[4*i +: 4];
  end

  // Shift the combined {BCD, binary} register left by one bit.
  always_comb begin
    dd_d  = {dd_adj[BW-2:0], bin_q[PW-1]};
    bin_d = {bin_q[PW-2:0], 1'b0};
  end

  // Control FSM with datapath registers and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      bin_q     <= '0;
      dd_q      <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
      bcd_q     <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, x};
            mplier_q <= y;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_MUL;
          end
        end
        S_MUL: begin
          acc_q    <= acc_d;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          if (cnt_q == CW'(WIDTH - 1)) begin
            // Seed the converter with the final accumulator value.
            cnt_q   <= '0;
            bin_q   <= acc_d;
            dd_q    <= '0;
            state_q <= S_CONV;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_CONV: begin
          bin_q <= bin_d;
          dd_q  <= dd_d;
          if (cnt_q == CW'(PW - 1)) begin
            // Results are published on the edge that enters DONE.
            cnt_q     <= '0;
            product_q <= acc_q;
            bcd_q     <= dd_d;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;
  assign bcd     = bcd_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_bcd_multiplier.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_seq_bcd_multiplier
// Purpose  : Directed self-checking bench for seq_bcd_multiplier at
//            WIDTH=4/DIGITS=3 and WIDTH=8/DIGITS=5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_bcd_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start;
  logic [3:0]  x, y;
  logic        busy, done;
  logic [7:0]  product;
  logic [11:0] bcd;

  logic        start8;
  logic [7:0]  x8, y8;
  logic        busy8, done8;
  logic [15:0] product8;
  logic [19:0] bcd8;

  int total = 0;
  int bad   = 0;

  seq_bcd_multiplier #(.WIDTH(4), .DIGITS(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .y(y),
    .busy(busy), .done(done), .product(product), .bcd(bcd)
  );

  seq_bcd_multiplier #(.WIDTH(8), .DIGITS(5)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .x(x8), .y(y8),
    .busy(busy8), .done(done8), .product(product8), .bcd(bcd8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Decimal reference built by repeated division.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned t;
    r = '0;
    t = v;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // One operation on the 4-bit instance; returns latency in edges (-1 on timeout).
  task automatic do_op4(input logic [3:0] a, input logic [3:0] b,
                        output int lat, output logic [7:0] p, output logic [11:0] bc);
    x = a; y = b; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    p  = product;
    bc = bcd;
    tick();
  endtask

  task automatic do_op8(input logic [7:0] a, input logic [7:0] b,
                        output int lat, output logic [15:0] p, output logic [19:0] bc);
    x8 = a; y8 = b; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = -1;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (done8) begin
        lat = k;
        break;
      end
    end
    p  = product8;
    bc = bcd8;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; x = '0; y = '0;
    start8 = 1'b0; x8 = '0; y8 = '0;
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    total++; if (product !== 8'h00) begin bad++; $display("FAIL reset_product got=%h exp=00", product); end
    total++; if (bcd !== 12'h000) begin bad++; $display("FAIL reset_bcd got=%h exp=000", bcd); end
    total++; if (bcd8 !== 20'h0 || product8 !== 16'h0) begin
      bad++; $display("FAIL reset_wide got=%h/%h exp=0/0", product8, bcd8);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_max();
    int lat;
    x = 4'd15; y = 4'd15; start = 1'b1;
    tick();
    start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL max_busy got=%b exp=1", busy); end
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin lat = k; break; end
    end
    total++; if (lat !== 12) begin bad++; $display("FAIL max_latency got=%0d exp=12", lat); end
    total++; if (product !== 8'hE1) begin bad++; $display("FAIL max_product got=%h exp=e1", product); end
    total++; if (bcd !== 12'h225) begin bad++; $display("FAIL max_bcd got=%h exp=225", bcd); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL max_done_pulse got=%b exp=0", done); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL max_busy_after got=%b exp=0", busy); end
  endtask

  task automatic test_input_change();
    int lat;
    int ndone;
    logic [7:0]  p;
    logic [11:0] bc;
    x = 4'd7; y = 4'd9; start = 1'b1;
    tick();                     // accepting edge
    start = 1'b0;
    tick(); tick();             // edges 1,2 in MUL
    x = 4'd3; y = 4'd3;
    tick(); tick(); tick();     // edges 3..5, now in CONV
    start = 1'b1;
    tick();                     // edge 6, start must be ignored
    start = 1'b0;
    lat = -1; ndone = 0; p = '0; bc = '0;
    for (int k = 7; k <= 30; k++) begin
      tick();
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = k; p = product; bc = bcd; end
      end
    end
    total++; if (ndone !== 1) begin bad++; $display("FAIL chg_done_count got=%0d exp=1", ndone); end
    total++; if (lat !== 12) begin bad++; $display("FAIL chg_latency got=%0d exp=12", lat); end
    total++; if (p !== 8'd63) begin bad++; $display("FAIL chg_product got=%0d exp=63", p); end
    total++; if (bc !== 12'h063) begin bad++; $display("FAIL chg_bcd got=%h exp=063", bc); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL chg_idle got=%b exp=0", busy); end
  endtask

  task automatic test_zero();
    int lat;
    int held_bad;
    x = 4'd0; y = 4'd13; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1; held_bad = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done) begin lat = k; break; end
      if (product !== 8'd63 || bcd !== 12'h063) held_bad++;
    end
    total++; if (held_bad !== 0) begin bad++; $display("FAIL zero_hold got=%0d changed cycles exp=0", held_bad); end
    total++; if (lat !== 12) begin bad++; $display("FAIL zero_latency got=%0d exp=12", lat); end
    total++; if (product !== 8'h00) begin bad++; $display("FAIL zero_product got=%h exp=00", product); end
    total++; if (bcd !== 12'h000) begin bad++; $display("FAIL zero_bcd got=%h exp=000", bcd); end
    tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    int ndone;
    logic [7:0]  p;
    logic [11:0] bc;
    x = 4'd12; y = 4'd11; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k <= 6; k++) tick();   // into CONV
    #2 rst_n = 1'b0;
    #1;
    total++; if (product !== 8'h00 || bcd !== 12'h000) begin
      bad++; $display("FAIL rstmid_outputs got=%h/%h exp=00/000", product, bcd);
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    #2 rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (done) ndone++;
    end
    total++; if (ndone !== 0) begin bad++; $display("FAIL rstmid_no_done got=%0d exp=0", ndone); end
    do_op4(4'd12, 4'd11, lat, p, bc);
    total++; if (lat !== 12) begin bad++; $display("FAIL rstmid_latency got=%0d exp=12", lat); end
    total++; if (p !== 8'd132) begin bad++; $display("FAIL rstmid_product got=%0d exp=132", p); end
    total++; if (bc !== 12'h132) begin bad++; $display("FAIL rstmid_bcd got=%h exp=132", bc); end
  endtask

  task automatic test_back_to_back();
    int hits[$];
    int res_bad;
    int wait_n;
    x = 4'd9; y = 4'd9; start = 1'b1;
    tick();                     // first accept
    res_bad = 0;
    for (int k = 1; k <= 45; k++) begin
      tick();
      if (done) begin
        hits.push_back(k);
        if (product !== 8'd81 || bcd !== 12'h081) res_bad++;
      end
    end
    start = 1'b0;
    total++; if (hits.size() !== 3) begin bad++; $display("FAIL b2b_count got=%0d exp=3", hits.size()); end
    total++; if (hits.size() >= 1 && hits[0] !== 12) begin bad++; $display("FAIL b2b_first got=%0d exp=12", hits[0]); end
    total++; if (hits.size() >= 3 && (hits[1] - hits[0] !== 14 || hits[2] - hits[1] !== 14)) begin
      bad++; $display("FAIL b2b_period got=%0d,%0d exp=14,14", hits[1] - hits[0], hits[2] - hits[1]);
    end
    total++; if (res_bad !== 0) begin bad++; $display("FAIL b2b_results got=%0d wrong exp=0", res_bad); end
    wait_n = 0;
    while (busy && wait_n < 50) begin tick(); wait_n++; end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%b exp=0", busy); end
    tick();
  endtask

  task automatic test_sweep();
    int lat;
    logic [7:0]  p;
    logic [11:0] bc;
    logic [19:0] eb;
    int unsigned e;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op4(4'(a), 4'(b), lat, p, bc);
        e  = a * b;
        eb = ref_bcd(e);
        total++;
        if (p !== 8'(e) || bc !== eb[11:0] || lat !== 12) begin
          bad++;
          $display("FAIL sweep %0d*%0d got=%0d/%h/lat%0d exp=%0d/%h/lat12", a, b, p, bc, lat, e, eb[11:0]);
        end
      end
    end
  endtask

  task automatic test_wide();
    int lat;
    logic [15:0] p;
    logic [19:0] bc;
    do_op8(8'd255, 8'd255, lat, p, bc);
    total++; if (lat !== 24) begin bad++; $display("FAIL wide_latency got=%0d exp=24", lat); end
    total++; if (p !== 16'hFE01) begin bad++; $display("FAIL wide_product got=%h exp=fe01", p); end
    total++; if (bc !== 20'h65025) begin bad++; $display("FAIL wide_bcd got=%h exp=65025", bc); end
    do_op8(8'd200, 8'd123, lat, p, bc);
    total++; if (p !== 16'd24600 || bc !== 20'h24600) begin
      bad++; $display("FAIL wide_200x123 got=%0d/%h exp=24600/24600", p, bc);
    end
    do_op8(8'd0, 8'd255, lat, p, bc);
    total++; if (p !== 16'd0 || bc !== 20'h0 || lat !== 24) begin
      bad++; $display("FAIL wide_zero got=%0d/%h/lat%0d exp=0/00000/lat24", p, bc, lat);
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_input_change();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    test_sweep();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
